// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: shared AHB codes, arbitration policy constants, FSM encoding
// and burst length decoding for the bus-matrix output-stage arbiter.
package ahb_arb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_BURST, ST_LOCKED} arb_state_e;

    // Undefined-length INCR counts as one beat: it never earns burst protection.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        return (hburst == HBURST_SINGLE || hburst == HBURST_INCR)  ? 5'd1 :
               (hburst == HBURST_WRAP4  || hburst == HBURST_INCR4) ? 5'd4 :
               (hburst == HBURST_WRAP8  || hburst == HBURST_INCR8) ? 5'd8 :
               (hburst == HBURST_WRAP16 || hburst == HBURST_INCR16) ? 5'd16 : 5'd1;
    endfunction
endpackage

// File: rtl/ahb_arb_rr_pick.sv
// ahb_arb_rr_pick: rotating priority encoder; mode=0 picks the lowest set bit,
// mode=1 searches upward from ptr+1 with wrap.
module ahb_arb_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] cand,
    input  logic [W-1:0] ptr,
    input  logic         mode,
    output logic [W-1:0] idx,
    output logic         any
);
    int j;

    always_comb begin
        idx = '0;
        any = 1'b0;
        j = 0;
        for (int k = 0; k < N; k++) begin
            j = mode ? (int'(ptr) + 1 + k) % N : k;
            if (!any && cand[j]) begin
                idx = W'(j);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ahb_arbiter_nport.sv
// ahb_arbiter_nport: output-stage arbiter choosing which input stage owns a
// shared slave's address phase, with lock/burst protection and data-phase tracking.
module ahb_arbiter_nport
    import ahb_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ARB_MODE   = 1,
    parameter int BURST_HOLD = 1,
    localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic [PORT_W-1:0]    data_in_port,
    output logic                 no_port,
    output logic                 data_valid
);
    arb_state_e           state_q, state_d;
    logic [PORT_W-1:0]    addr_q, addr_d, data_q, rr_ptr_q, rr_ptr_d, pick_idx;
    logic                 no_port_q, no_port_d, data_valid_q, pick_any, active;
    logic [NUM_PORTS-1:0] cand;
    logic [3:0]           beat_q, beat_d, beat_upd;

    assign active = HSELM & (HTRANSM != HTRANS_IDLE);
    // The current owner stays a candidate while it is mid-transfer, even with req low.
    assign cand = req | ((NUM_PORTS'(1) << addr_q) & {NUM_PORTS{active & ~no_port_q}});

    // An IDLE beat from the owner also serves as early burst termination.
    assign beat_upd = (no_port_q || HTRANSM == HTRANS_IDLE) ? 4'd0 :
                      !HSELM                    ? beat_q :
                      HTRANSM == HTRANS_NONSEQ  ? 4'(burst_beats(HBURSTM) - 5'd1) :
                      HTRANSM == HTRANS_BUSY    ? beat_q :
                      beat_q - {3'b0, |beat_q};

    ahb_arb_rr_pick #(.N(NUM_PORTS), .W(PORT_W)) u_pick (
        .cand(cand),
        .ptr (rr_ptr_q),
        .mode(ARB_MODE != ARB_FIXED),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        no_port_d = no_port_q;
        rr_ptr_d  = rr_ptr_q;
        beat_d    = beat_upd;
        if (state_q != ST_IDLE && HMASTLOCKM) begin
            state_d = ST_LOCKED;
        end else if (BURST_HOLD != 0 && state_q != ST_IDLE && beat_upd != 4'd0) begin
            state_d = ST_BURST;
        end else if (pick_any) begin
            state_d   = ST_ARB;
            addr_d    = pick_idx;
            no_port_d = 1'b0;
            if (state_q == ST_IDLE || pick_idx != addr_q) begin
                rr_ptr_d = pick_idx;
                beat_d   = 4'd0;
            end
        end else if (state_q != ST_IDLE && HSELM) begin
            state_d = ST_ARB;
        end else begin
            state_d   = ST_IDLE;
            no_port_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            no_port_q    <= 1'b1;
            data_valid_q <= 1'b0;
            rr_ptr_q     <= PORT_W'(NUM_PORTS - 1);
            beat_q       <= '0;
        end else if (HREADYM) begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            no_port_q    <= no_port_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_q       <= beat_d;
            data_q       <= addr_q;
            data_valid_q <= ~no_port_q & active;
        end
    end

    assign addr_in_port = addr_q;
    assign data_in_port = data_q;
    assign no_port      = no_port_q;
    assign data_valid   = data_valid_q;
endmodule
